// File: rtl/dp_wb_mem_sequencer_pkg.sv
// Shared definitions for the skylark memory-side controllers.
package skylark_mem_pkg;

  // Access sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } mem_state_t;

  // Default number of BUSY cycles tolerated without an ack.
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd255;

  // Counter width able to hold 0..limit, never narrower than one bit.
  function automatic int unsigned timeout_cnt_w(input int unsigned limit);
    return (limit == 32'd0) ? 32'd1 : $clog2(limit + 32'd1);
  endfunction

endpackage

// File: rtl/dp_wb_mem_sequencer_if.sv
// External data-memory req/ack port: the sequencer is the master.
interface dp_wb_mem_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_err, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_err, mem_rdata
  );
endinterface

// File: rtl/dp_mem_timeout_counter.sv
// BUSY-cycle counter; o_tc flags the last cycle allowed before abort.
module dp_mem_timeout_counter
  import skylark_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = timeout_cnt_w(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  // Terminal count is TIMEOUT_CYCLES-1; a zero limit never terminates.
  localparam int unsigned TC_VAL = (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : (TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] TC = CNT_W'(TC_VAL);

  logic [CNT_W-1:0] r_cnt;

  // Count BUSY cycles without ack; restart at each new request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (TIMEOUT_CYCLES != 32'd0) && (r_cnt == TC);

endmodule

// File: rtl/dp_wb_mem_sequencer.sv
// WB-stage data-memory sequencer: issues the WB load/store on the req/ack
// port, stalls the pipeline until ack or timeout, and defers EX flushes
// of the WB register until the stall releases.
module dp_wb_mem_sequencer
  import skylark_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = timeout_cnt_w(TIMEOUT_CYCLES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemReqW,
  input  logic                  MemWriteW,
  input  logic [31:0]           ALUResultW,
  input  logic [31:0]           RD2_W,
  input  logic                  FlushReqE,
  dp_wb_mem_sequencer_if.master mem_bus,
  output logic                  StallW,
  output logic                  FlushW,
  output logic [31:0]           ReadDataW,
  output logic                  ReadValidW,
  output logic                  ErrW
);

  mem_state_t  r_state;
  mem_state_t  w_state_nxt;
  logic        w_cnt_clr;
  logic        w_cnt_en;
  logic        w_tc;
  logic        w_go_busy;
  logic        w_go_done;
  logic        w_go_fault;
  logic        w_stall;
  logic        w_flush;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_err;
  logic        r_flush_pend;

  dp_mem_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_cnt_clr),
    .i_enable (w_cnt_en),
    .o_tc     (w_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, transition strobes and timeout counter control; ack beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_go_busy   = 1'b0;
    w_go_done   = 1'b0;
    w_go_fault  = 1'b0;
    case (r_state)
      IDLE: begin
        if (MemReqW) begin
          w_state_nxt = BUSY;
          w_go_busy   = 1'b1;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (mem_bus.mem_ack) begin
          if (mem_bus.mem_err) begin
            w_state_nxt = FAULT;
            w_go_fault  = 1'b1;
          end else begin
            w_state_nxt = DONE;
            w_go_done   = 1'b1;
          end
        end else if (w_tc) begin
          w_state_nxt = FAULT;
          w_go_fault  = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      FAULT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_stall = ((r_state == IDLE) && MemReqW) || (r_state == BUSY);
  assign w_flush = (FlushReqE || r_flush_pend) && !w_stall;

  // Request flag and operands: captured once at issue, held until the next issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
    end else if (w_go_busy) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= MemWriteW;
      r_mem_addr  <= ALUResultW;
      r_mem_wdata <= RD2_W;
    end else if (w_go_done || w_go_fault) begin
      r_mem_req   <= 1'b0;
    end else begin
      r_mem_req   <= r_mem_req;
    end
  end

  // Completion strobes and load result; a fault zeroes the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0000_0000;
    end else begin
      r_rvalid <= w_go_done && !r_mem_we;
      r_err    <= w_go_fault;
      if (w_go_done && !r_mem_we) begin
        r_rdata <= mem_bus.mem_rdata;
      end else if (w_go_fault) begin
        r_rdata <= 32'h0000_0000;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  // Remember a flush requested while stalled until it can be applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_pend <= 1'b0;
    end else if (w_flush) begin
      r_flush_pend <= 1'b0;
    end else if (FlushReqE && w_stall) begin
      r_flush_pend <= 1'b1;
    end else begin
      r_flush_pend <= r_flush_pend;
    end
  end

  assign mem_bus.mem_req   = r_mem_req;
  assign mem_bus.mem_we    = r_mem_we;
  assign mem_bus.mem_addr  = r_mem_addr;
  assign mem_bus.mem_wdata = r_mem_wdata;
  assign StallW            = w_stall;
  assign FlushW            = w_flush;
  assign ReadDataW         = r_rdata;
  assign ReadValidW        = r_rvalid;
  assign ErrW              = r_err;

endmodule

// File: doc/dp_wb_mem_sequencer.md
# dp_wb_mem_sequencer

Write-back-stage data-memory sequencer for the two-stage EX/WB datapath. It takes the load/store held in the EX/WB pipeline register and drives a req/ack external memory port. It stalls the pipeline until the access completes or times out, and defers EX-requested flushes of the WB register until the stall releases.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, max BUSY cycles without ack before abort; 0 disables timeout
- CNT_W, $clog2(TIMEOUT_CYCLES+1) (min 1), timeout counter width

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- MemReqW  in  1  instruction in WB is a load or store
- MemWriteW  in  1  1 = store, 0 = load (valid with MemReqW)
- ALUResultW  in  32  word address
- RD2_W  in  32  store data
- FlushReqE  in  1  EX redirect requests flush of instruction entering WB
- mem_ack  in  1  memory completes current request
- mem_err  in  1  bus error, qualified by mem_ack
- mem_rdata  in  32  load data, qualified by mem_ack
- mem_req  out  1  request valid (registered)
- mem_we  out  1  write enable (registered)
- mem_addr  out  32  address (registered)
- mem_wdata  out  32  write data (registered)
- StallW  out  1  hold EX/WB register and upstream
- FlushW  out  1  flush EX/WB register
- ReadDataW  out  32  load result, valid when ReadValidW
- ReadValidW  out  1  one-cycle load completion strobe
- ErrW  out  1  one-cycle access fault strobe (error or timeout)

## Operation
- States: IDLE, BUSY, DONE, FAULT.
- IDLE, MemReqW=1: go to BUSY. Capture ALUResultW, RD2_W and MemWriteW into mem_addr, mem_wdata and mem_we. Set mem_req=1 and clear the counter.
- IDLE, MemReqW=0: stay. mem_ack is ignored.
- BUSY, mem_ack=1, mem_err=0: go to DONE and drop mem_req. For a load, capture mem_rdata into ReadDataW.
- BUSY, mem_ack=1, mem_err=1: go to FAULT and drop mem_req.
- BUSY, no ack, counter = TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): go to FAULT and drop mem_req. Otherwise increment the counter.
- DONE: ReadValidW=1 for loads only, then go to IDLE.
- FAULT: ErrW=1, ReadDataW=0, then go to IDLE.
- StallW = (IDLE & MemReqW) | BUSY. It is combinational and is 0 in DONE and FAULT.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1. mem_req never deasserts without ack or timeout.
- Flush deferral:
  - flush_pending is set when FlushReqE & StallW.
  - FlushW = (FlushReqE | flush_pending) & ~StallW.
  - flush_pending is cleared in the cycle FlushW=1.
- ReadDataW holds its last value outside DONE. FAULT zeroes it.

## Timing
- Reset values:
  - state IDLE, counter 0, flush_pending 0
  - mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, ReadDataW 0
  - ReadValidW 0, ErrW 0
  - StallW 0 and FlushW 0 (given MemReqW=0 and FlushReqE=0)
- Stall latency: with ack in the first BUSY cycle, StallW=1 for 2 cycles (IDLE-detect, BUSY). DONE follows, and the EX/WB register advances at the end of DONE.
- Ack after N BUSY cycles gives N+1 stall cycles.
- Back-to-back accesses: a new MemReqW is sampled in the IDLE cycle after DONE/FAULT, with no bubble beyond that.
- Timeout: FAULT is entered on the edge after TIMEOUT_CYCLES BUSY cycles without ack.
- An ack in the same cycle as the timeout count wins; the normal ack path is taken.
- Reset mid-BUSY: mem_req drops asynchronously and the request is abandoned. A pending flush is discarded.
- FlushReqE and stall release in the same cycle (DONE): FlushW=1 that cycle.

## Structure
- Package skylark_mem_pkg:
  - state typedef enum logic [1:0] {IDLE, BUSY, DONE, FAULT}
  - default timeout constant
  - shared by other memory-side controllers
- Sub-module dp_mem_timeout_counter (clear, enable, terminal-count output, TIMEOUT_CYCLES/CNT_W parameters). Instantiated once.

## Test plan
- Load, immediate ack: MemReqW=1, MemWriteW=0, ALUResultW=0x100 -> mem_req=1, mem_addr=0x100 next cycle. mem_rdata=0xDEADBEEF with ack -> StallW high 2 cycles, then ReadValidW=1 and ReadDataW=0xDEADBEEF.
- Store, ack after 3 cycles: RD2_W=0x12345678 -> mem_we=1 and mem_wdata=0x12345678 stable for 4 cycles. StallW high 4 cycles. ReadValidW stays 0. ErrW stays 0.
- Timeout: TIMEOUT_CYCLES=4, no ack -> mem_req high exactly 4 cycles, then ErrW=1 for 1 cycle, ReadDataW=0, StallW=0.
- Bus error: ack with mem_err=1 on cycle 2 of BUSY -> FAULT, ErrW pulse, no ReadValidW.
- Deferred flush: FlushReqE pulses 1 cycle during BUSY -> FlushW=0 while stalled, then FlushW=1 in the DONE cycle, and flush_pending is cleared afterward.
- Reset mid-BUSY: assert reset during BUSY -> mem_req=0 immediately, then IDLE. A later ack is ignored and no ReadValidW or ErrW pulse occurs.
